// File: rtl/qpsk_tx_ctrl.sv
// qpsk_tx_ctrl: frame sequencer driving the QPSK modulator bit input with preamble, LSB-first payload, optional CRC-8 and a gap
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_start, i_len          frame request and payload byte count, sampled in IDLE
//   i_byte, i_byte_valid    upstream payload byte stream
//   o_byte_ready            byte accepted this cycle when i_byte_valid is high
//   o_bit, o_bit_valid      serial bit and one-cycle strobe to the modulator
//   o_busy, o_done          frame in progress, one-cycle end-of-frame pulse
// Optional feature: define QPSK_TX_CRC_EN to append a CRC-8 (poly 0x07, MSB first) after the payload.
module qpsk_tx_ctrl #(
  parameter logic [15:0] PREAMBLE     = 16'hCCCC,
  parameter int          PREAMBLE_LEN = 16,
  parameter int          BIT_DIV      = 1,
  parameter int          GAP_CYCLES   = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [7:0] i_len,
  input  logic [7:0] i_byte,
  input  logic       i_byte_valid,
  output logic       o_byte_ready,
  output logic       o_bit,
  output logic       o_bit_valid,
  output logic       o_busy,
  output logic       o_done
);
  localparam int DW = BIT_DIV > 1 ? $clog2(BIT_DIV) : 1;
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
`ifdef QPSK_TX_CRC_EN
  typedef enum logic [2:0] {IDLE, PRE, PAY, CRC, GAP} state_t;
  localparam state_t TAIL = CRC;
`else
  typedef enum logic [1:0] {IDLE, PRE, PAY, GAP} state_t;
  localparam state_t TAIL = GAP;
`endif
  state_t state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] buf_q, buf_d;
  logic [3:0] idx_q, idx_d;
  logic [DW-1:0] div_q, div_d;
  logic [GW-1:0] gap_q, gap_d;
  logic full_q, full_d;
  logic bit_q, bit_d;
  logic bit_valid_q, bit_valid_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic avail, emit, cur_bit;
`ifdef QPSK_TX_CRC_EN
  logic [7:0] crc_q, crc_d;
  assign avail = state_q == PRE || state_q == CRC || (state_q == PAY && full_q);
  assign cur_bit = state_q == PRE ? PREAMBLE[idx_q] : state_q == PAY ? buf_q[idx_q[2:0]] : crc_q[7];
`else
  assign avail = state_q == PRE || (state_q == PAY && full_q);
  assign cur_bit = state_q == PRE ? PREAMBLE[idx_q] : buf_q[idx_q[2:0]];
`endif
  // prefetch starts in PRE so the first payload byte is normally ready when the preamble ends
  assign o_byte_ready = (state_q == PRE || state_q == PAY) && !full_q && acc_q < len_q;
  // an empty buffer at a slot leaves the divider parked at 0 until a byte lands
  assign emit = avail && div_q == '0;
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    acc_d = acc_q;
    idx_d = idx_q;
    div_d = div_q;
    gap_d = state_q == GAP ? gap_q + 1'b1 : '0;
    buf_d = buf_q;
    full_d = full_q;
    bit_d = emit ? cur_bit : 1'b0;
    bit_valid_d = emit;
    done_d = 1'b0;
`ifdef QPSK_TX_CRC_EN
    crc_d = crc_q;
`endif
    if (div_q != '0 || emit) div_d = div_q == DW'(BIT_DIV - 1) ? '0 : div_q + 1'b1;
    if (emit) idx_d = idx_q + 4'd1;
    if (o_byte_ready && i_byte_valid) begin
      buf_d = i_byte;
      full_d = 1'b1;
      acc_d = acc_q + 8'd1;
    end
    case (state_q)
      IDLE: if (i_start) begin
        state_d = PRE;
        len_d = i_len;
        acc_d = '0;
        idx_d = '0;
        div_d = '0;
        full_d = 1'b0;
`ifdef QPSK_TX_CRC_EN
        crc_d = '0;
`endif
      end
      PRE: if (emit && idx_q == 4'(PREAMBLE_LEN - 1)) begin
        idx_d = '0;
        state_d = len_q != 8'd0 ? PAY : TAIL;
      end
      PAY: if (emit) begin
`ifdef QPSK_TX_CRC_EN
        crc_d = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ cur_bit) ? 8'h07 : 8'h00);
`endif
        // all len bytes accepted while one is still buffered means this is the last byte
        if (idx_q == 4'd7) begin
          idx_d = '0;
          full_d = 1'b0;
          if (acc_q == len_q) state_d = TAIL;
        end
      end
`ifdef QPSK_TX_CRC_EN
      CRC: if (emit) begin
        crc_d = {crc_q[6:0], 1'b0};
        if (idx_q == 4'd7) begin
          idx_d = '0;
          state_d = GAP;
        end
      end
`endif
      GAP: if (gap_q == GW'(GAP_CYCLES - 1)) begin
        state_d = IDLE;
        done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_q != IDLE && !done_d;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      len_q <= '0;
      acc_q <= '0;
      buf_q <= '0;
      idx_q <= '0;
      div_q <= '0;
      gap_q <= '0;
      full_q <= 1'b0;
      bit_q <= 1'b0;
      bit_valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef QPSK_TX_CRC_EN
      crc_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      acc_q <= acc_d;
      buf_q <= buf_d;
      idx_q <= idx_d;
      div_q <= div_d;
      gap_q <= gap_d;
      full_q <= full_d;
      bit_q <= bit_d;
      bit_valid_q <= bit_valid_d;
      busy_q <= busy_d;
      done_q <= done_d;
`ifdef QPSK_TX_CRC_EN
      crc_q <= crc_d;
`endif
    end
  end
  assign o_bit = bit_q;
  assign o_bit_valid = bit_valid_q;
  assign o_busy = busy_q;
  assign o_done = done_q;
endmodule

// File: tb/tb_qpsk_tx_ctrl.sv
// tb_qpsk_tx_ctrl: self-checking bench for qpsk_tx_ctrl, two instances (BIT_DIV 1 and 3) against a frame-level reference model
module tb_qpsk_tx_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] st = '0, vl = '0;
  logic [1:0] rdy, bt, bv, bsy, dn;
  logic [1:0][7:0] ln = '0, by = '0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic ob[$];
  int ot[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  qpsk_tx_ctrl #(.PREAMBLE(16'h000A), .PREAMBLE_LEN(4), .BIT_DIV(1), .GAP_CYCLES(4)) u0 (
    .i_clk(clk), .i_reset(rst), .i_start(st[0]), .i_len(ln[0]), .i_byte(by[0]), .i_byte_valid(vl[0]),
    .o_byte_ready(rdy[0]), .o_bit(bt[0]), .o_bit_valid(bv[0]), .o_busy(bsy[0]), .o_done(dn[0]));
  qpsk_tx_ctrl #(.PREAMBLE(16'hCCCC), .PREAMBLE_LEN(16), .BIT_DIV(3), .GAP_CYCLES(2)) u1 (
    .i_clk(clk), .i_reset(rst), .i_start(st[1]), .i_len(ln[1]), .i_byte(by[1]), .i_byte_valid(vl[1]),
    .o_byte_ready(rdy[1]), .o_bit(bt[1]), .o_bit_valid(bv[1]), .o_busy(bsy[1]), .o_done(dn[1]));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle(input int d);
    chk($sformatf("rst_bit_u%0d", d), bt[d], 0);
    chk($sformatf("rst_bit_valid_u%0d", d), bv[d], 0);
    chk($sformatf("rst_byte_ready_u%0d", d), rdy[d], 0);
    chk($sformatf("rst_busy_u%0d", d), bsy[d], 0);
    chk($sformatf("rst_done_u%0d", d), dn[d], 0);
  endtask
  // One frame on instance d: len bytes (byte 0 forced to 'first' if >=0), byte 'sb' withheld for 'sl'
  // ready cycles, optional start pokes in PRE and GAP, optional reset once 'rst_at' bits were seen.
  task automatic frame(input int d, input int len, input int first, input int sb, input int sl, input bit poke, input int rst_at);
    int bd = d ? 3 : 1;
    int pl = d ? 16 : 4;
    int gp = d ? 2 : 4;
    logic [15:0] pre = d ? 16'hCCCC : 16'h000A;
    logic [7:0] dat[$];
    logic [7:0] v;
    logic eb[$];
    int at[$];
    int k, t, tp;
    int j = 0, sc = 0, ndone = 0, tdone = -1, rise = -1, fall = -1, rises = 0, bad_rdy = 0, extra = -1;
    logic pb = 1'b0, pg = 1'b0, pbusy = 1'b0;
`ifdef QPSK_TX_CRC_EN
    logic [7:0] crc = '0;
    logic fb;
`endif
    ob.delete();
    ot.delete();
    for (int i = 0; i < len; i++) dat.push_back(i == 0 && first >= 0 ? 8'(first) : 8'($urandom));
    for (int i = 0; i < pl; i++) eb.push_back(pre[i]);
    for (int i = 0; i < len; i++) begin
      v = dat[i];
      for (int b = 0; b < 8; b++) eb.push_back(v[b]);
    end
`ifdef QPSK_TX_CRC_EN
    for (int i = pl; i < pl + 8 * len; i++) begin
      fb = crc[7] ^ eb[i];
      crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    for (int b = 7; b >= 0; b--) eb.push_back(crc[b]);
`endif
    @(negedge clk);
    st[d] = 1'b1;
    ln[d] = 8'(len);
    k = cyc + 1;
    for (int c = 0; c < 3000 && (extra < 0 || c < extra); c++) begin
      @(negedge clk);
      st[d] = 1'b0;
      if (bv[d]) begin
        ob.push_back(bt[d]);
        ot.push_back(cyc - k);
      end
      if (dn[d]) begin
        ndone++;
        if (tdone < 0) begin
          tdone = cyc - k;
          extra = c + 12;
        end
      end
      if (bsy[d] && !pbusy) begin
        rises++;
        if (rise < 0) rise = cyc - k;
      end
      if (!bsy[d] && pbusy && fall < 0) fall = cyc - k;
      pbusy = bsy[d];
      if (poke && !pb && cyc - k == 2) begin
        st[d] = 1'b1;
        pb = 1'b1;
      end
      if (poke && !pg && ob.size() == eb.size()) begin
        st[d] = 1'b1;
        pg = 1'b1;
      end
      if (rst_at >= 0 && ob.size() == rst_at) begin
        vl[d] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk_idle(d);
        @(negedge clk);
        chk_idle(d);
        rst = 1'b0;
        return;
      end
      #1;
      if (rdy[d] && j >= len) bad_rdy++;
      if (j < len && !(j == sb && sc < sl)) begin
        vl[d] = 1'b1;
        by[d] = dat[j];
        if (rdy[d]) begin
          at.push_back(cyc + 1 - k);
          j++;
        end
      end else begin
        vl[d] = 1'b0;
        if (j == sb && rdy[d]) sc++;
      end
    end
    vl[d] = 1'b0;
    chk($sformatf("u%0d_bytes_accepted", d), j, len);
    chk($sformatf("u%0d_ready_after_last", d), bad_rdy, 0);
    chk($sformatf("u%0d_bit_count", d), ob.size(), eb.size());
    tp = 0;
    for (int i = 0; i < eb.size(); i++) begin
      t = i == 0 ? 1 : tp + bd;
      if (i >= pl && i < pl + 8 * len && (i - pl) % 8 == 0 && at.size() > (i - pl) / 8 && at[(i - pl) / 8] + 1 > t)
        t = at[(i - pl) / 8] + 1;
      if (i < ob.size()) begin
        chk($sformatf("u%0d_bit%0d", d, i), ob[i], eb[i]);
        chk($sformatf("u%0d_bit%0d_time", d, i), ot[i], t);
      end
      tp = t;
    end
    chk($sformatf("u%0d_done_count", d), ndone, 1);
    chk($sformatf("u%0d_done_time", d), tdone, tp + gp);
    chk($sformatf("u%0d_busy_rise", d), rise, 1);
    chk($sformatf("u%0d_busy_fall", d), fall, tp + gp);
    chk($sformatf("u%0d_busy_rises", d), rises, 1);
  endtask
  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle(0);
    chk_idle(1);
    rst = 1'b0;
    @(negedge clk);
    frame(0, 0, -1, -1, 0, 1'b1, -1);
    frame(1, 1, 8'hA5, -1, 0, 1'b0, -1);
    frame(0, 2, -1, 1, 5, 1'b0, -1);
    frame(0, 1, 8'h01, -1, 0, 1'b0, -1);
`ifdef QPSK_TX_CRC_EN
    begin
      logic [7:0] c = '0;
      if (ob.size() >= 8)
        for (int i = 0; i < 8; i++) c = {c[6:0], ob[ob.size() - 8 + i]};
      chk("crc_of_0x01", c, 8'h89);
    end
`endif
    frame(1, 3, -1, -1, 0, 1'b0, 19);
    frame(1, 2, -1, -1, 0, 1'b0, -1);
    for (int r = 0; r < 6; r++)
      frame(r % 2, int'($urandom_range(0, 4)), -1, int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), r < 2, -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
